// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the VGA overlay path. Walks a pixel counter (x)
//   and a line counter (y) across the full raster, including blanking, and
//   produces registered sync, visible-area and wrap-pulse outputs that line up
//   with the coordinates presented in the same cycle.
//
//   Default geometry: 640x480@60 with negative-polarity syncs.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ce           in   pixel clock enable; the raster advances only when high
//   x            out  [9:0] horizontal count, 0..H_TOTAL-1
//   y            out  [9:0] vertical count,   0..V_TOTAL-1
//   frame_active out  high when x < H_ACTIVE and y < V_ACTIVE
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low (a function of y only)
//   line_start   out  one-clk pulse after every horizontal wrap
//   frame_start  out  one-clk pulse after every frame wrap
//   frame_count  out  [7:0] frame counter, only with VGA_FRAME_COUNT_EN
//
// Build option
//   VGA_FRAME_COUNT_EN : when defined, adds frame_count, which increments
//                        (mod 256) on the edge that raises frame_start.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so neither total may exceed 1024.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL (%0d) and V_TOTAL (%0d) must be <= 1024",
           H_TOTAL, V_TOTAL);
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Thresholds are 11 bits: a sync end may sit exactly at 1024.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_frame_active;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;

  logic        w_x_last;
  logic        w_y_last;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic [10:0] w_x_nxt_ext;
  logic [10:0] w_y_nxt_ext;
  logic        w_active_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;

  // Next-coordinate logic. Sync and active flags are decoded from the next
  // coordinates so that, once registered, they match the registered x/y.
  always_comb begin
    w_x_last = (r_x == H_LAST);
    w_y_last = (r_y == V_LAST);

    w_x_nxt = w_x_last ? '0 : r_x + 10'd1;
    w_y_nxt = r_y;
    if (w_x_last) begin
      w_y_nxt = w_y_last ? '0 : r_y + 10'd1;
    end

    w_x_nxt_ext  = {1'b0, w_x_nxt};
    w_y_nxt_ext  = {1'b0, w_y_nxt};
    w_active_nxt = (w_x_nxt_ext < H_ACT_END) && (w_y_nxt_ext < V_ACT_END);
    w_hsync_nxt  = !((w_x_nxt_ext >= H_SYNC_BEG) && (w_x_nxt_ext < H_SYNC_END));
    w_vsync_nxt  = !((w_y_nxt_ext >= V_SYNC_BEG) && (w_y_nxt_ext < V_SYNC_END));
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x            <= '0;
      r_y            <= '0;
      r_frame_active <= 1'b1;
      r_hsync        <= 1'b1;
      r_vsync        <= 1'b1;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
      r_frame_count  <= '0;
`endif
    end else if (ce) begin
      r_x            <= w_x_nxt;
      r_y            <= w_y_nxt;
      r_frame_active <= w_active_nxt;
      r_hsync        <= w_hsync_nxt;
      r_vsync        <= w_vsync_nxt;
      r_line_start   <= w_x_last;
      r_frame_start  <= w_x_last && w_y_last;
`ifdef VGA_FRAME_COUNT_EN
      if (w_x_last && w_y_last) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
`else
      // No frame counter in this build.
`endif
    end else begin
      // Raster holds while ce is low, but the pulses must stay one clk wide.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign frame_active = r_frame_active;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
`ifdef VGA_FRAME_COUNT_EN
  assign frame_count  = r_frame_count;
`endif

endmodule
